fft_bitrev_reorder: RTL
=======================

// Module: fft_bitrev_reorder
// PURPOSE
//  Output-side reorder buffer for the R2^2 SDF FFT chain. Accepts complete frames in bit-reversed order
//  (as emitted by the FFT core's do_en/do_re/do_im) and re-emits each frame in natural order.
//  Ping-pong banks: one bank fills while the other drains, so back-to-back frames stream without stalls.
// PARAMETERS
//  N      128  frame length (points); power of two, >= 4
//  WIDTH  16   bit width of each of the real and imaginary parts
// PORTS
//  clock   in   1         master clock, rising edge
//  reset   in   1         asynchronous, active-low reset (0 = reset)
//  di_en   in   1         input sample valid
//  di_re   in   WIDTH     input real part, bit-reversed order
//  di_im   in   WIDTH     input imaginary part, bit-reversed order
//  do_en   out  1         output sample valid
//  do_re   out  WIDTH     output real part, natural order
//  do_im   out  WIDTH     output imaginary part, natural order
//  do_idx  out  log2(N)   natural frequency index of the current output sample
// BEHAVIOUR
//  Reset: do_en=0, do_re=0, do_im=0, do_idx=0. wcnt=0, wbank=0, pend=0, read FSM=IDLE.
//   Reset takes effect immediately (async), including mid-frame. A partially written frame is discarded.
//   A frame being drained is truncated. The first di_en after release is sample 0 of a new frame.
//  Storage: 2 banks x N words of 2*WIDTH bits. Data is stored unmodified (no scaling or rounding).
//  Write side:
//   - On each clock with di_en=1, store {di_re,di_im} at bank[wbank][bitrev(wcnt)], then wcnt++.
//   - Gaps (di_en=0) are allowed anywhere; wcnt holds during a gap.
//   - When wcnt wraps N-1 -> 0, bank wbank is marked full and wbank toggles.
//  Read FSM:
//   - IDLE: leave IDLE if a bank completed this cycle, or if pend=1. Latch rbank to that bank, clear pend,
//     set rcnt=0, go to READ.
//   - READ: issue a synchronous memory read at address rcnt each cycle; rcnt++.
//     After rcnt=N-1: if pend=1, restart READ on the other bank with rcnt=0, no idle cycle; else go to IDLE.
//   - A bank that completes while READ is active sets pend=1 (only one pending bank possible).
//  Output register stage:
//   - do_en/do_re/do_im/do_idx are registered 1 cycle after the read address.
//   - do_en is high for exactly N consecutive cycles per frame.
//   - do_idx = 0..N-1 ascending.
//   - do_re/do_im hold their last value while do_en=0.
//  Latency: input sample with wcnt=N-1 sampled at edge t -> do_en rises at edge t+2 (do_idx=0) and stays
//   high through edge t+N+1. With gapless input, the first output arrives N+1 cycles after the first input.
//  Throughput: gapless back-to-back input gives gapless back-to-back output.
//  Write into the draining bank cannot occur: refill takes >= N cycles, while the drain finishes in N.
//  Same-cycle write to bank X and read of bank Y != X is always legal (dual-port or two single-port banks).
//  Simultaneous frame completion and end of READ: the new bank starts READ the next cycle (pend path);
//   no frame is lost or duplicated.
// TESTING
//  T1 Impulse, N=128:
//   input sample 0 = (1000,0), all others 0 -> one do_en burst of 128; only do_idx=0 carries (1000,0).
//  T2 Ramp, N=128:
//   input k carries re=bitrev(k), im=-bitrev(k) -> output sample j has re=j, im=-j, do_idx=j, for all j.
//  T3 Back-to-back:
//   4 gapless frames of 128 -> 512 consecutive do_en cycles; first at cycle 129 after first input;
//   every frame correctly reordered.
//  T4 Gapped input:
//   di_en random ~50% duty -> output identical to T2, each burst 128 contiguous cycles;
//   burst starts 2 cycles after the 128th input.
//  T5 Reset mid-operation:
//   assert reset at input 60 of frame 1 and again mid-drain of frame 0 -> do_en=0 immediately;
//   next full frame after release outputs correctly with no stale data.
//  T6 Small N:
//   N=8 ramp, 3 back-to-back frames -> 24 consecutive outputs, do_idx 0..7 repeating, data = natural index.

Source files
------------

// File: rtl/fft_bitrev_reorder_if.sv
// ---------------------------------------------------------------------------
// fft_bitrev_reorder_if
//   Streaming bus for the FFT output reorder buffer. The input half carries
//   samples in bit-reversed order from the FFT core; the output half carries
//   the same frame re-emitted in natural order with its frequency index.
//
//   Signals
//     di_en   input sample valid
//     di_re   input real part
//     di_im   input imaginary part
//     do_en   output sample valid
//     do_re   output real part
//     do_im   output imaginary part
//     do_idx  natural frequency index of the current output sample
//
//   Modports
//     master  the side that feeds bit-reversed samples and consumes results
//     slave   the reorder buffer itself
// ---------------------------------------------------------------------------
interface fft_bitrev_reorder_if #(
  parameter int N     = 128,
  parameter int WIDTH = 16
) ();

  localparam int AW = $clog2(N);

  logic             di_en;
  logic [WIDTH-1:0] di_re;
  logic [WIDTH-1:0] di_im;
  logic             do_en;
  logic [WIDTH-1:0] do_re;
  logic [WIDTH-1:0] do_im;
  logic [AW-1:0]    do_idx;

  modport master (
    output di_en, di_re, di_im,
    input  do_en, do_re, do_im, do_idx
  );

  modport slave (
    input  di_en, di_re, di_im,
    output do_en, do_re, do_im, do_idx
  );

endinterface

// File: rtl/fft_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// fft_bitrev_reorder
//   Output-side reorder buffer for the FFT chain. Complete frames arrive in
//   bit-reversed order and leave in natural order. Two banks of N words are
//   used ping-pong: one bank fills while the other drains, so back-to-back
//   frames stream through without stalls.
//
//   Parameters
//     N      frame length in points (power of two, >= 4)
//     WIDTH  width of each of the real and imaginary parts
//
//   Ports
//     clock  master clock, rising edge
//     reset  asynchronous reset, active LOW (0 = in reset)
//     bus    fft_bitrev_reorder_if slave modport (di_* in, do_* out)
//
//   Timing: the last sample of a frame sampled at edge t gives do_en high
//   from edge t+2 for N consecutive cycles, do_idx counting 0..N-1.
// ---------------------------------------------------------------------------
module fft_bitrev_reorder #(
  parameter int N     = 128,
  parameter int WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  fft_bitrev_reorder_if.slave  bus
);

  localparam int AW = $clog2(N);

  typedef enum logic {
    IDLE,
    READ
  } rd_state_t;

  // Mirror the address bits so a bit-reversed arrival index lands at its
  // natural position in the bank.
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

  // Both banks live in one array; the top address bit selects the bank.
  logic [2*WIDTH-1:0] mem [0:2*N-1];

  logic [AW-1:0]      wcnt;
  logic               wbank;
  logic               wr_done;

  rd_state_t          state;
  logic               rbank;
  logic [AW-1:0]      rcnt;
  logic               pend;

  logic               rd_vld;
  logic [AW-1:0]      rd_idx;
  logic [2*WIDTH-1:0] rd_data;

  logic               do_en_q;
  logic [WIDTH-1:0]   do_re_q;
  logic [WIDTH-1:0]   do_im_q;
  logic [AW-1:0]      do_idx_q;

  // A frame is complete on the cycle its last sample is accepted.
  assign wr_done = bus.di_en && (wcnt == AW'(N - 1));

  // Storage write port. Data is kept exactly as received; the bit-reversed
  // arrival count is turned into the natural-order address here, so the read
  // side only has to walk addresses in ascending order.
  always_ff @(posedge clock) begin
    if (bus.di_en) begin
      mem[{wbank, bitrev(wcnt)}] <= {bus.di_re, bus.di_im};
    end
  end

  // Write-side bookkeeping. The count only advances on valid samples, so
  // gaps simply hold it. Wrapping back to zero hands the filled bank to the
  // reader and moves writing to the other bank. Reset drops any partial
  // frame because the count restarts at sample 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wcnt  <= '0;
      wbank <= 1'b0;
    end else if (bus.di_en) begin
      wcnt <= wcnt + 1'b1;
      if (wr_done) begin
        wbank <= ~wbank;
      end
    end
  end

  // Read sequencer. IDLE waits for a finished bank; READ walks the bank in
  // natural order, one address per cycle. A bank finishing while a drain is
  // in progress is remembered in pend, which can only ever hold one bank
  // because refilling takes at least N cycles. At the end of a drain the
  // next bank (pending, or finishing on this very cycle) starts at once so
  // back-to-back frames produce back-to-back output. rd_vld/rd_idx follow the
  // read address by one cycle, lining up with the memory read data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      rbank  <= 1'b0;
      rcnt   <= '0;
      pend   <= 1'b0;
      rd_vld <= 1'b0;
      rd_idx <= '0;
    end else begin
      rd_vld <= (state == READ);
      rd_idx <= rcnt;
      case (state)
        IDLE: begin
          if (wr_done || pend) begin
            rbank <= wr_done ? wbank : ~rbank;
            pend  <= 1'b0;
            rcnt  <= '0;
            state <= READ;
          end
        end
        READ: begin
          rcnt <= rcnt + 1'b1;
          if (rcnt == AW'(N - 1)) begin
            if (pend || wr_done) begin
              rbank <= ~rbank;
              pend  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else if (wr_done) begin
            pend <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Synchronous read port of the storage array.
  always_ff @(posedge clock) begin
    if (state == READ) begin
      rd_data <= mem[{rbank, rcnt}];
    end
  end

  // Output register stage. Data and index are only updated on valid cycles
  // so the outputs hold their last value between bursts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      do_en_q  <= 1'b0;
      do_re_q  <= '0;
      do_im_q  <= '0;
      do_idx_q <= '0;
    end else begin
      do_en_q <= rd_vld;
      if (rd_vld) begin
        do_re_q  <= rd_data[2*WIDTH-1:WIDTH];
        do_im_q  <= rd_data[WIDTH-1:0];
        do_idx_q <= rd_idx;
      end
    end
  end

  assign bus.do_en  = do_en_q;
  assign bus.do_re  = do_re_q;
  assign bus.do_im  = do_im_q;
  assign bus.do_idx = do_idx_q;

endmodule
